vector_fu_pipe: RTL and testbench

//  Parametrised, pipelined successor to the combinational vector FU.

---
 rtl/vector_fu_pipe.sv | 92 +++++++++
 tb/tb_vector_fu_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_fu_pipe.sv
// Lane-wise integer vector FU (add/sub/mul/logic/shift); VECTOR_FU_SAT_EN makes add/sub signed-saturating.
// Latency: accept at edge N -> out_valid after edge N+PIPE_DEPTH-1; one op per cycle sustained.
// Backpressure: in_ready = !out_valid | out_ready; a stalled output freezes every stage.
module vector_fu_pipe #(
    parameter int LANES      = 4,
    parameter int WIDTH      = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a [0:LANES-1],
    input  logic [WIDTH-1:0] b [0:LANES-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result [0:LANES-1],
    output logic             busy
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                  advance;
    logic                  accept;
    logic [WIDTH-1:0]      comp [0:LANES-1];
    logic [PIPE_DEPTH-1:0] stg_vld;
    logic [WIDTH-1:0]      stg_dat [0:PIPE_DEPTH-1][0:LANES-1];

`ifdef VECTOR_FU_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Sign-extended sum: overflow shows as disagreement between the top two bits.
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] s);
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? SAT_MIN : SAT_MAX;
        return s[WIDTH-1:0];
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            comp[i] = '0;
            case (op)
`ifdef VECTOR_FU_SAT_EN
                3'b000:  comp[i] = sat({a[i][WIDTH-1], a[i]} + {b[i][WIDTH-1], b[i]});
                3'b001:  comp[i] = sat({a[i][WIDTH-1], a[i]} - {b[i][WIDTH-1], b[i]});
`else
                3'b000:  comp[i] = a[i] + b[i];
                3'b001:  comp[i] = a[i] - b[i];
`endif
                3'b010:  comp[i] = a[i] * b[i];
                3'b011:  comp[i] = a[i] & b[i];
                3'b100:  comp[i] = a[i] | b[i];
                3'b101:  comp[i] = a[i] ^ b[i];
                3'b110:  comp[i] = a[i] << b[i][SHW-1:0];
                default: comp[i] = '0;
            endcase
        end
    end

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    assign out_valid = stg_vld[PIPE_DEPTH-1];
    assign busy      = |stg_vld;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            result[i] = stg_dat[PIPE_DEPTH-1][i];
    end

    // Bubbles keep stale data in stage 0; only the valid bit matters downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++)
                for (int i = 0; i < LANES; i++)
                    stg_dat[s][i] <= '0;
        end else if (advance) begin
            stg_vld[0] <= accept;
            if (accept)
                for (int i = 0; i < LANES; i++)
                    stg_dat[0][i] <= comp[i];
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                stg_vld[s] <= stg_vld[s-1];
                for (int i = 0; i < LANES; i++)
                    stg_dat[s][i] <= stg_dat[s-1][i];
            end
        end
    end
endmodule

// File: tb/tb_vector_fu_pipe.sv
// Scoreboard bench for vector_fu_pipe: stimulus pushes expected vectors, a negedge monitor pops and compares.
module tb_vector_fu_pipe #(
    parameter int LANES      = 4,
    parameter int WIDTH      = 32,
    parameter int PIPE_DEPTH = 2
);
    typedef logic [LANES*WIDTH-1:0] vec_t;

    localparam logic [31:0] MAXV = 32'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [31:0] MINV = 32'(64'd1 << (WIDTH-1));

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] a_arr [0:LANES-1];
    logic [WIDTH-1:0] b_arr [0:LANES-1];
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result [0:LANES-1];
    logic             busy;

    vec_t a_flat = '0;
    vec_t b_flat = '0;
    vec_t res_flat;
    vec_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign a_arr[i] = a_flat[i*WIDTH +: WIDTH];
        assign b_arr[i] = b_flat[i*WIDTH +: WIDTH];
        assign res_flat[i*WIDTH +: WIDTH] = result[i];
    end

    vector_fu_pipe #(.LANES(LANES), .WIDTH(WIDTH), .PIPE_DEPTH(PIPE_DEPTH)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a_arr), .b(b_arr), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Lane i takes value v[i%4], truncated to the lane width.
    function automatic vec_t pack4(input logic [31:0] v0, v1, v2, v3);
        vec_t        r;
        logic [31:0] t;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            case (i % 4)
                0: t = v0;
                1: t = v1;
                2: t = v2;
                default: t = v3;
            endcase
            r[i*WIDTH +: WIDTH] = t[WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic vec_t rep(input logic [31:0] v);
        return pack4(v, v, v, v);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, expv);
        end
    endtask

    // Holds in_valid high until the op is accepted, then pushes its expected result.
    task automatic send(input logic [2:0] o, input vec_t av, input vec_t bv, input vec_t ev);
        bit done;
        int n;
        in_valid = 1'b1;
        op       = o;
        a_flat   = av;
        b_flat   = bv;
        done     = 1'b0;
        n        = 0;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                n++;
                if (n > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout op %0d never accepted", o);
                    return;
                end
            end
        end
        exp_q.push_back(ev);
    endtask

    // Monitor: compare on every output handshake, and check hold-stability across stalls.
    bit   prev_stall = 1'b0;
    vec_t prev_res;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || res_flat !== prev_res) begin
                    errors++;
                    $display("FAIL stall_hold valid %b result %h required valid 1 result %h",
                             out_valid, res_flat, prev_res);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output result %h with empty scoreboard", res_flat);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    if (res_flat !== e) begin
                        errors++;
                        $display("FAIL result got %h expected %h", res_flat, e);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = res_flat;
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        vec_t ta, tb;
        int   n;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(res_flat), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Test 1: add and exact latency
        ta = pack4(32'h5, 32'h8, 32'h12, 32'h20);
        tb = pack4(32'h2, 32'h4, 32'h6, 32'h10);
        send(3'b000, ta, tb, pack4(32'h7, 32'hC, 32'h18, 32'h30));
        in_valid = 1'b0;
        for (int e = 0; e < PIPE_DEPTH; e++) begin
            @(negedge clk);
            check($sformatf("latency_edge%0d", e), 64'(out_valid), 64'(e == PIPE_DEPTH-1));
            if (e < PIPE_DEPTH-1) @(posedge clk);
        end
        drain();

        // Test 2: sub then mul back-to-back, results on consecutive cycles
        send(3'b001, ta, tb, pack4(32'h3, 32'h4, 32'hC, 32'h10));
        send(3'b010, ta, tb, pack4(32'hA, 32'h20, 32'h6C, 32'h200));
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("b2b_second_valid", 64'(out_valid), 64'd1);
        drain();

        // Test 3: four adds with a three-cycle stall mid-stream
        fork
            begin
                send(3'b000, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), pack4(11, 22, 33, 44));
                send(3'b000, pack4(32'h100, 32'h200, 32'h300, 32'h400), rep(1),
                     pack4(32'h101, 32'h201, 32'h301, 32'h401));
                send(3'b000, pack4(32'hFFFF_FFFF, 7, 9, 0), pack4(1, 1, 1, 5), pack4(0, 8, 10, 5));
                send(3'b000, pack4(100, 200, 300, 400), rep(50), pack4(150, 250, 350, 450));
                in_valid = 1'b0;
            end
            begin
                repeat (PIPE_DEPTH) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check($sformatf("stall_in_ready%0d", s), 64'(in_ready), 64'd0);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Test 4: logic and shift ops; shift amount uses only the low log2(WIDTH) bits
        ta = rep(32'hF0F0_F0F0);
        tb = rep(32'h0000_0004);
        send(3'b011, ta, tb, rep(32'h0));
        send(3'b100, ta, tb, rep(32'hF0F0_F0F4));
        send(3'b101, ta, tb, rep(32'hF0F0_F0F4));
        send(3'b110, ta, tb, rep(32'h0F0F_0F00));
        send(3'b111, ta, tb, rep(32'h0));
        send(3'b110, ta, rep(32'h0000_0024), rep(32'h0F0F_0F00));
        in_valid = 1'b0;
        drain();

        // Test 5: signed overflow on add and sub
`ifdef VECTOR_FU_SAT_EN
        send(3'b000, pack4(MAXV, 5, 0, 0), rep(1), pack4(MAXV, 6, 1, 1));
        send(3'b001, pack4(MINV, 5, 0, 0), rep(1), pack4(MINV, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
`else
        send(3'b000, pack4(MAXV, 5, 0, 0), rep(1), pack4(MINV, 6, 1, 1));
        send(3'b001, pack4(MINV, 5, 0, 0), rep(1), pack4(MAXV, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
`endif
        in_valid = 1'b0;
        drain();

        // Test 6: reset with two ops in flight under backpressure
        out_ready = 1'b0;
        send(3'b000, rep(1), rep(1), rep(2));
        send(3'b000, rep(3), rep(3), rep(6));
        in_valid = 1'b0;
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", 64'(res_flat), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (PIPE_DEPTH + 4) @(posedge clk);
        #1;
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
